// File: rtl/lsu_ctrl.sv
// Load/store unit between the MEM stage and the data memory req/gnt/rvalid bus.
// Handles lane alignment, byte enables, load extension, misalignment errors and in-order responses.
module lsu_ctrl #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TAG_WIDTH       = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      lsu_req_i,
  output logic                      lsu_ready_o,
  input  logic                      lsu_we_i,
  input  logic [1:0]                lsu_type_i,
  input  logic                      lsu_sign_ext_i,
  input  logic [ADDR_WIDTH-1:0]     lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]     lsu_wdata_i,
  input  logic [TAG_WIDTH-1:0]      lsu_tag_i,
  output logic                      lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0]     lsu_rdata_o,
  output logic [TAG_WIDTH-1:0]      lsu_rtag_o,
  output logic                      lsu_rwe_o,
  output logic                      lsu_err_o,
  output logic                      lsu_busy_o,
  output logic                      data_req_o,
  input  logic                      data_gnt_i,
  input  logic                      data_rvalid_i,
  output logic                      data_we_o,
  output logic [DATA_WIDTH/8-1:0]   data_be_o,
  output logic [ADDR_WIDTH-1:0]     data_addr_o,
  output logic [DATA_WIDTH-1:0]     data_wdata_o,
  input  logic [DATA_WIDTH-1:0]     data_rdata_i
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned OFFS  = $clog2(BE_W);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  typedef struct packed {
    logic                 we;
    logic [1:0]           size;
    logic                 sext;
    logic [OFFS-1:0]      offs;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  logic [CNT_W-1:0]      cnt_q;
  logic [PTR_W-1:0]      wptr_q;
  logic [PTR_W-1:0]      rptr_q;
  entry_t                fifo_q [MAX_OUTSTANDING];

  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [TAG_WIDTH-1:0]  rtag_q;
  logic                  rwe_q;
  logic                  err_q;

  logic                  aligned;
  logic                  room;
  logic                  issue_ok;
  logic                  err_ok;
  logic                  push;
  logic                  pop;
  logic [OFFS-1:0]       offs;
  logic [BE_W-1:0]       mask;
  entry_t                head;
  entry_t                new_entry;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] size_mask;
  logic                  sign;
  logic [DATA_WIDTH-1:0] load_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Alignment check and lane mask for the incoming request
  always_comb begin
    aligned = 1'b0;
    mask    = '0;
    unique case (size_e'(lsu_type_i))
      SZ_BYTE: begin
        aligned = 1'b1;
        mask    = BE_W'(1);
      end
      SZ_HALF: begin
        aligned = (lsu_addr_i[0] == 1'b0);
        mask    = BE_W'(3);
      end
      SZ_WORD: begin
        aligned = (lsu_addr_i[1:0] == 2'b00);
        mask    = BE_W'(4'hF);
      end
      default: begin
        aligned = (DATA_WIDTH == 64) && (lsu_addr_i[2:0] == 3'b000);
        mask    = '1;
      end
    endcase
  end

  assign offs     = lsu_addr_i[OFFS-1:0];
  assign room     = (cnt_q < CNT_W'(MAX_OUTSTANDING));
  assign issue_ok = rst_ni & lsu_req_i & aligned & room;
  // Errored requests wait for an empty pipe so their response stays in order
  assign err_ok   = rst_ni & lsu_req_i & ~aligned & (cnt_q == '0);
  assign push     = issue_ok & data_gnt_i;
  assign pop      = data_rvalid_i & (cnt_q != '0);

  assign data_req_o   = issue_ok;
  assign lsu_ready_o  = push | err_ok;
  assign data_we_o    = issue_ok & lsu_we_i;
  assign data_be_o    = issue_ok ? BE_W'(mask << offs) : '0;
  assign data_addr_o  = issue_ok ? {lsu_addr_i[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}} : '0;
  assign data_wdata_o = (issue_ok & lsu_we_i) ? (lsu_wdata_i << {offs, 3'b000}) : '0;

  assign new_entry.we   = lsu_we_i;
  assign new_entry.size = lsu_type_i;
  assign new_entry.sext = lsu_sign_ext_i;
  assign new_entry.offs = offs;
  assign new_entry.tag  = lsu_tag_i;

  assign head    = fifo_q[rptr_q];
  assign shifted = data_rdata_i >> {head.offs, 3'b000};

  // Size masking and sign/zero extension of the returned lane
  always_comb begin
    size_mask = '1;
    sign      = 1'b0;
    unique case (size_e'(head.size))
      SZ_BYTE: begin
        size_mask = DATA_WIDTH'(8'hFF);
        sign      = head.sext & shifted[7];
      end
      SZ_HALF: begin
        size_mask = DATA_WIDTH'(16'hFFFF);
        sign      = head.sext & shifted[15];
      end
      SZ_WORD: begin
        size_mask = DATA_WIDTH'(32'hFFFF_FFFF);
        sign      = head.sext & shifted[31];
      end
      default: begin
        size_mask = '1;
        sign      = 1'b0;
      end
    endcase
    load_data = sign ? (shifted | ~size_mask) : (shifted & size_mask);
  end

  // Transaction FIFO storage; contents are don't-care while empty
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wptr_q] <= new_entry;
    end
  end

  // Pointers, outstanding count and registered response
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rtag_q   <= '0;
      rwe_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      rvalid_q <= pop | err_ok;
      err_q    <= err_ok & ~pop;
      if (pop) begin
        rdata_q <= head.we ? '0 : load_data;
        rtag_q  <= head.tag;
        rwe_q   <= head.we;
      end else if (err_ok) begin
        rdata_q <= '0;
        rtag_q  <= lsu_tag_i;
        rwe_q   <= lsu_we_i;
      end
    end
  end

  assign lsu_rvalid_o = rvalid_q;
  assign lsu_rdata_o  = rdata_q;
  assign lsu_rtag_o   = rtag_q;
  assign lsu_rwe_o    = rwe_q;
  assign lsu_err_o    = err_q;
  assign lsu_busy_o   = (cnt_q != '0);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a 32-bit/2-outstanding instance and a 64-bit/1-outstanding instance.
module tb_lsu_ctrl;

  typedef struct {
    logic [63:0] rdata;
    logic [4:0]  tag;
    logic        rwe;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t sb32[$];
  exp_t sb64[$];

  // 32-bit instance signals
  logic        req, we, sext, gnt, rv;
  logic [1:0]  typ;
  logic [31:0] addr, wdata, rdata;
  logic [4:0]  tag;
  logic        ready, lrv, lrwe, lerr, busy, dreq, dwe;
  logic [3:0]  be;
  logic [31:0] daddr, dwdata, lrdata;
  logic [4:0]  rtag;

  // 64-bit instance signals
  logic        w_req, w_we, w_sext, w_gnt, w_rv;
  logic [1:0]  w_typ;
  logic [31:0] w_addr;
  logic [63:0] w_wdata, w_rdata;
  logic [4:0]  w_tag;
  logic        w_ready, w_lrv, w_lrwe, w_lerr, w_busy, w_dreq, w_dwe;
  logic [7:0]  w_be;
  logic [31:0] w_daddr;
  logic [63:0] w_dwdata, w_lrdata;
  logic [4:0]  w_rtag;

  lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_OUTSTANDING(2), .TAG_WIDTH(5)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n),
    .lsu_req_i(req), .lsu_ready_o(ready), .lsu_we_i(we), .lsu_type_i(typ),
    .lsu_sign_ext_i(sext), .lsu_addr_i(addr), .lsu_wdata_i(wdata), .lsu_tag_i(tag),
    .lsu_rvalid_o(lrv), .lsu_rdata_o(lrdata), .lsu_rtag_o(rtag), .lsu_rwe_o(lrwe),
    .lsu_err_o(lerr), .lsu_busy_o(busy),
    .data_req_o(dreq), .data_gnt_i(gnt), .data_rvalid_i(rv), .data_we_o(dwe),
    .data_be_o(be), .data_addr_o(daddr), .data_wdata_o(dwdata), .data_rdata_i(rdata)
  );

  lsu_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MAX_OUTSTANDING(1), .TAG_WIDTH(5)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n),
    .lsu_req_i(w_req), .lsu_ready_o(w_ready), .lsu_we_i(w_we), .lsu_type_i(w_typ),
    .lsu_sign_ext_i(w_sext), .lsu_addr_i(w_addr), .lsu_wdata_i(w_wdata), .lsu_tag_i(w_tag),
    .lsu_rvalid_o(w_lrv), .lsu_rdata_o(w_lrdata), .lsu_rtag_o(w_rtag), .lsu_rwe_o(w_lrwe),
    .lsu_err_o(w_lerr), .lsu_busy_o(w_busy),
    .data_req_o(w_dreq), .data_gnt_i(w_gnt), .data_rvalid_i(w_rv), .data_we_o(w_dwe),
    .data_be_o(w_be), .data_addr_o(w_daddr), .data_wdata_o(w_dwdata), .data_rdata_i(w_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] t, input logic s,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] tg);
    req = r; we = w; typ = t; sext = s; addr = a; wdata = wd; tag = tg;
  endtask

  task automatic bus(input logic g, input logic v, input logic [31:0] d);
    gnt = g; rv = v; rdata = d;
  endtask

  task automatic exp32(input logic [63:0] d, input logic [4:0] tg, input logic w, input logic e);
    exp_t x;
    x.rdata = d; x.tag = tg; x.rwe = w; x.err = e;
    sb32.push_back(x);
  endtask

  task automatic exp64(input logic [63:0] d, input logic [4:0] tg, input logic w, input logic e);
    exp_t x;
    x.rdata = d; x.tag = tg; x.rwe = w; x.err = e;
    sb64.push_back(x);
  endtask

  // Response monitor, 32-bit instance
  always @(negedge clk) begin
    if (rst_n === 1'b1 && lrv === 1'b1) begin
      if (sb32.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp32_unexpected: got rvalid tag=%0d expected none", rtag);
      end else begin
        exp_t e;
        e = sb32.pop_front();
        chk("rsp32_rdata", 64'(lrdata), e.rdata);
        chk("rsp32_tag",   64'(rtag),   64'(e.tag));
        chk("rsp32_rwe",   64'(lrwe),   64'(e.rwe));
        chk("rsp32_err",   64'(lerr),   64'(e.err));
      end
    end
  end

  // Response monitor, 64-bit instance
  always @(negedge clk) begin
    if (rst_n === 1'b1 && w_lrv === 1'b1) begin
      if (sb64.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp64_unexpected: got rvalid tag=%0d expected none", w_rtag);
      end else begin
        exp_t e;
        e = sb64.pop_front();
        chk("rsp64_rdata", w_lrdata,     e.rdata);
        chk("rsp64_tag",   64'(w_rtag),  64'(e.tag));
        chk("rsp64_rwe",   64'(w_lrwe),  64'(e.rwe));
        chk("rsp64_err",   64'(w_lerr),  64'(e.err));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
    bus(0, 0, 32'h0);
    w_req = 0; w_we = 0; w_typ = 2'b00; w_sext = 0; w_addr = '0; w_wdata = '0; w_tag = '0;
    w_gnt = 0; w_rv = 0; w_rdata = '0;

    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_rvalid", 64'(lrv),  64'd0);
    chk("rst_req",    64'(dreq), 64'd0);
    chk("rst_ready",  64'(ready), 64'd0);
    chk("rst_err",    64'(lerr), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // 1: signed byte load at 0x1003
    drive(1, 0, 2'b00, 1, 32'h1003, 32'h0, 5'd1);
    bus(1, 0, 32'h0);
    @(negedge clk);
    chk("t1_req",   64'(dreq),  64'd1);
    chk("t1_ready", 64'(ready), 64'd1);
    chk("t1_be",    64'(be),    64'h8);
    chk("t1_addr",  64'(daddr), 64'h1000);
    chk("t1_we",    64'(dwe),   64'd0);
    exp32(64'hFFFF_FF80, 5'd1, 1'b0, 1'b0);
    step();
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
    bus(0, 1, 32'h80FF_FF12);
    @(negedge clk);
    chk("t1_busy", 64'(busy), 64'd1);
    step();
    bus(0, 0, 32'h0);
    @(negedge clk);
    chk("t1_idle", 64'(busy), 64'd0);
    step();

    // 2: half store at 0x2002
    drive(1, 1, 2'b01, 0, 32'h2002, 32'h0000_BEEF, 5'd2);
    bus(1, 0, 32'h0);
    @(negedge clk);
    chk("t2_be",    64'(be),     64'hC);
    chk("t2_wdata", 64'(dwdata), 64'hBEEF_0000);
    chk("t2_we",    64'(dwe),    64'd1);
    chk("t2_addr",  64'(daddr),  64'h2000);
    exp32(64'h0, 5'd2, 1'b1, 1'b0);
    step();
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
    bus(0, 1, 32'hDEAD_BEEF);
    step();
    bus(0, 0, 32'h0);
    step();

    // 3: three back-to-back loads, rvalid 4 cycles after grant
    drive(1, 0, 2'b10, 0, 32'h100, 32'h0, 5'd1);
    bus(1, 0, 32'h0);
    @(negedge clk);
    chk("t3_ready1", 64'(ready), 64'd1);
    exp32(64'h1111_1111, 5'd1, 1'b0, 1'b0);
    step();
    drive(1, 0, 2'b10, 0, 32'h104, 32'h0, 5'd2);
    @(negedge clk);
    chk("t3_ready2", 64'(ready), 64'd1);
    exp32(64'h2222_2222, 5'd2, 1'b0, 1'b0);
    step();
    drive(1, 0, 2'b10, 0, 32'h108, 32'h0, 5'd3);
    @(negedge clk);
    chk("t3_hold_a", 64'(dreq), 64'd0);
    step();
    @(negedge clk);
    chk("t3_hold_b", 64'(dreq), 64'd0);
    step();
    bus(1, 1, 32'h1111_1111);
    @(negedge clk);
    chk("t3_hold_at_rvalid", 64'(dreq), 64'd0);
    step();
    bus(1, 1, 32'h2222_2222);
    @(negedge clk);
    chk("t3_req3",   64'(dreq),  64'd1);
    chk("t3_ready3", 64'(ready), 64'd1);
    exp32(64'h3333_3333, 5'd3, 1'b0, 1'b0);
    step();
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
    bus(0, 0, 32'h0);
    step(); step(); step();
    bus(0, 1, 32'h3333_3333);
    step();
    bus(0, 0, 32'h0);
    step();
    @(negedge clk);
    chk("t3_idle", 64'(busy), 64'd0);
    step();

    // 4: misaligned word load waits for the outstanding load to drain
    drive(1, 0, 2'b00, 0, 32'h400, 32'h0, 5'd4);
    bus(1, 0, 32'h0);
    exp32(64'h0000_00AB, 5'd4, 1'b0, 1'b0);
    step();
    drive(1, 0, 2'b10, 0, 32'h3002, 32'h0, 5'd5);
    @(negedge clk);
    chk("t4_ready_wait", 64'(ready), 64'd0);
    chk("t4_noreq_a",    64'(dreq),  64'd0);
    step();
    bus(1, 1, 32'h1234_56AB);
    @(negedge clk);
    chk("t4_ready_at_rvalid", 64'(ready), 64'd0);
    step();
    bus(1, 0, 32'h0);
    @(negedge clk);
    chk("t4_ready_err", 64'(ready), 64'd1);
    chk("t4_noreq_b",   64'(dreq),  64'd0);
    exp32(64'h0, 5'd5, 1'b0, 1'b1);
    step();
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
    bus(0, 0, 32'h0);
    step(); step();

    // 5: simultaneous grant/rvalid, then reset with a response pending
    drive(1, 0, 2'b10, 0, 32'h500, 32'h0, 5'd6);
    bus(1, 0, 32'h0);
    exp32(64'hAAAA_5555, 5'd6, 1'b0, 1'b0);
    step();
    drive(1, 0, 2'b10, 0, 32'h504, 32'h0, 5'd7);
    bus(1, 1, 32'hAAAA_5555);
    @(negedge clk);
    chk("t5_ready_pushpop", 64'(ready), 64'd1);
    step();
    drive(1, 0, 2'b10, 0, 32'h508, 32'h0, 5'd8);
    bus(0, 0, 32'h0);
    @(negedge clk);
    chk("t5_cnt1_room", 64'(dreq),  64'd1);
    chk("t5_cnt1_busy", 64'(busy),  64'd1);
    chk("t5_nogrant",   64'(ready), 64'd0);
    step();
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    step();
    bus(0, 1, 32'h7777_7777);
    step();
    bus(0, 0, 32'h0);
    @(negedge clk);
    chk("t5_stray_rvalid", 64'(lrv), 64'd0);
    chk("t5_stray_busy",   64'(busy), 64'd0);
    step();

    // 6a: dword on a 32-bit bus and a misaligned store are errors
    drive(1, 0, 2'b11, 0, 32'h8, 32'h0, 5'd9);
    @(negedge clk);
    chk("t6_illegal_ready", 64'(ready), 64'd1);
    chk("t6_illegal_noreq", 64'(dreq),  64'd0);
    exp32(64'h0, 5'd9, 1'b0, 1'b1);
    step();
    drive(1, 1, 2'b01, 0, 32'h2001, 32'h1234, 5'd10);
    @(negedge clk);
    chk("t6_mis_store_ready", 64'(ready), 64'd1);
    exp32(64'h0, 5'd10, 1'b1, 1'b1);
    step();
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
    step(); step();

    // 6b: 64-bit bus, dword load then a held signed byte load (one outstanding)
    w_req = 1; w_we = 0; w_typ = 2'b11; w_sext = 0; w_addr = 32'h8; w_tag = 5'd3; w_gnt = 1;
    @(negedge clk);
    chk("t6_w_be",    64'(w_be),    64'hFF);
    chk("t6_w_addr",  64'(w_daddr), 64'h8);
    chk("t6_w_ready", 64'(w_ready), 64'd1);
    exp64(64'h0123_4567_89AB_CDEF, 5'd3, 1'b0, 1'b0);
    step();
    w_typ = 2'b00; w_sext = 1; w_addr = 32'hD; w_tag = 5'd4;
    @(negedge clk);
    chk("t6_w_full", 64'(w_dreq), 64'd0);
    step();
    w_rv = 1; w_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    chk("t6_w_nobypass", 64'(w_dreq), 64'd0);
    step();
    w_rv = 0; w_rdata = '0;
    @(negedge clk);
    chk("t6_w_req2",   64'(w_dreq),  64'd1);
    chk("t6_w_be2",    64'(w_be),    64'h20);
    chk("t6_w_addr2",  64'(w_daddr), 64'h8);
    chk("t6_w_ready2", 64'(w_ready), 64'd1);
    exp64(64'hFFFF_FFFF_FFFF_FF9A, 5'd4, 1'b0, 1'b0);
    step();
    w_req = 0; w_gnt = 0; w_rv = 1; w_rdata = 64'h0000_9A00_0000_0000;
    step();
    w_rv = 0; w_rdata = '0;
    step(); step();

    chk("sb32_drained", 64'(sb32.size()), 64'd0);
    chk("sb64_drained", 64'(sb64.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
